bsw_job_scheduler: RTL and testbench

Shares one BandedSWAccelerator between NREQ independent read-pair requesters. It arbitrates round-robin and latches the winning R/Q job. It then sequences the accelerator (start pulse, completion detect, watchdog) and returns the aligned pair with the requester ID over a valid/ready response channel. It sits between the read-fetch front end and the single accelerator instance.

---
 rtl/bsw_pkg.sv | 30 +++
 rtl/bsw_rr_arbiter.sv | 42 ++++
 rtl/bsw_job_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_bsw_job_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsw_pkg.sv
// bsw_pkg: shared definitions for the banded Smith-Waterman job scheduler.
//   - default sequence lengths and the derived bus widths
//   - scheduler state encoding
//   - id_width(): width of a requester index for a given requester count
package bsw_pkg;

  localparam int BASE_W   = 2;                  // bits per base / aligned symbol
  localparam int DEF_RLEN = 12;                 // bases per input sequence
  localparam int DEF_ALEN = 15;                 // symbols per aligned output
  localparam int SEQ_W    = BASE_W * DEF_RLEN;  // input sequence bus width
  localparam int ALN_W    = BASE_W * DEF_ALEN;  // aligned output bus width

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  // A single requester still needs a one-bit index bus.
  function automatic int id_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/bsw_rr_arbiter.sv
// bsw_rr_arbiter: purely combinational round-robin arbiter.
//   req  - request vector
//   ptr  - index where the search starts (highest priority)
//   en   - arbitration enable; no grant when low
//   gnt  - one-hot grant (or zero)
//   idx  - encoded index of the granted requester (0 when no grant)
// The pointer register belongs to the caller.
module bsw_rr_arbiter
  import bsw_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx
);

  logic            found;
  logic [ID_W-1:0] cand;

  // Search upward from ptr with wrap-around; the first set request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NREQ);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/bsw_job_scheduler.sv
// bsw_job_scheduler: shares one banded Smith-Waterman accelerator between
// NREQ requesters.
//   req_valid/req_ready/req_R/req_Q - per-requester job intake (packed slots)
//   rsp_*                           - valid/ready response with requester id
//   acc_*                           - accelerator start, inputs and results
//   busy, jobs_done, timeouts       - status and statistics
// Flow: IDLE (grant) -> LAUNCH (start pulse) -> WAIT_LOW (ignore stale done)
//       -> WAIT_HIGH (capture result) -> RESP (hold until accepted) -> IDLE.
module bsw_job_scheduler
  import bsw_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int RLEN      = DEF_RLEN,
  parameter int ALEN      = DEF_ALEN,
  parameter int START_CYC = 1,
  parameter int TIMEOUT   = 1024,
  localparam int ID_W     = id_width(NREQ),
  localparam int S_W      = BASE_W * RLEN,
  localparam int A_W      = BASE_W * ALEN
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*S_W-1:0] req_R,
  input  logic [NREQ*S_W-1:0] req_Q,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [A_W-1:0]      rsp_R_aligned,
  output logic [A_W-1:0]      rsp_Q_aligned,
  output logic                rsp_timeout,
  output logic                acc_start,
  output logic [S_W-1:0]      acc_R,
  output logic [S_W-1:0]      acc_Q,
  input  logic [A_W-1:0]      acc_R_aligned,
  input  logic [A_W-1:0]      acc_Q_aligned,
  input  logic                acc_ready,
  output logic                busy,
  output logic [15:0]         jobs_done,
  output logic [7:0]          timeouts
);

  localparam int SC_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] job_id_q, job_id_d;
  logic [S_W-1:0]  job_r_q, job_r_d;
  logic [S_W-1:0]  job_qs_q, job_qs_d;
  logic [SC_W-1:0] start_cnt_q, start_cnt_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            acc_start_q, acc_start_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [A_W-1:0]  rsp_r_q, rsp_r_d;
  logic [A_W-1:0]  rsp_qa_q, rsp_qa_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            busy_q, busy_d;
  logic [15:0]     jobs_done_q, jobs_done_d;
  logic [7:0]      timeouts_q, timeouts_d;

  logic [NREQ-1:0] gnt_s;
  logic [ID_W-1:0] gnt_idx_s;
  logic            arb_en_s;
  logic            wdog_exp_s;

  // Grants only in IDLE, and never while reset is applied.
  assign arb_en_s   = (state_q == ST_IDLE) && reset_n;
  // The current cycle is the TIMEOUT-th counted cycle since LAUNCH entry.
  assign wdog_exp_s = (wdog_q >= WD_W'(TIMEOUT - 1));

  bsw_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (arb_en_s),
    .gnt (gnt_s),
    .idx (gnt_idx_s)
  );

  assign req_ready     = gnt_s;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = job_id_q;
  assign rsp_R_aligned = rsp_r_q;
  assign rsp_Q_aligned = rsp_qa_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign acc_start     = acc_start_q;
  assign acc_R         = job_r_q;
  assign acc_Q         = job_qs_q;
  assign busy          = busy_q;
  assign jobs_done     = jobs_done_q;
  assign timeouts      = timeouts_q;

  // Next-state and next-output computation for the job sequencer.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    job_id_d      = job_id_q;
    job_r_d       = job_r_q;
    job_qs_d      = job_qs_q;
    start_cnt_d   = start_cnt_q;
    wdog_d        = wdog_q;
    acc_start_d   = acc_start_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_r_d       = rsp_r_q;
    rsp_qa_d      = rsp_qa_q;
    rsp_timeout_d = rsp_timeout_q;
    jobs_done_d   = jobs_done_q;
    timeouts_d    = timeouts_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt_s) begin
          job_id_d    = gnt_idx_s;
          job_r_d     = req_R[int'(gnt_idx_s) * S_W +: S_W];
          job_qs_d    = req_Q[int'(gnt_idx_s) * S_W +: S_W];
          rr_ptr_d    = (int'(gnt_idx_s) == NREQ - 1) ? '0 : gnt_idx_s + ID_W'(1);
          start_cnt_d = '0;
          wdog_d      = '0;
          acc_start_d = 1'b1;
          state_d     = ST_LAUNCH;
        end else begin
          acc_start_d = 1'b0;
        end
      end
      ST_LAUNCH: begin
        wdog_d = wdog_q + WD_W'(1);
        if (start_cnt_q == SC_W'(START_CYC - 1)) begin
          acc_start_d = 1'b0;
          state_d     = ST_WAIT_LOW;
        end else begin
          start_cnt_d = start_cnt_q + SC_W'(1);
          acc_start_d = 1'b1;
        end
      end
      ST_WAIT_LOW, ST_WAIT_HIGH: begin
        wdog_d = wdog_q + WD_W'(1);
        // Completion is only valid after the low phase; it beats the watchdog.
        if ((state_q == ST_WAIT_HIGH) && acc_ready) begin
          rsp_r_d       = acc_R_aligned;
          rsp_qa_d      = acc_Q_aligned;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if (wdog_exp_s) begin
          rsp_r_d       = '0;
          rsp_qa_d      = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          timeouts_d    = (timeouts_q == 8'hFF) ? 8'hFF : timeouts_q + 8'd1;
          state_d       = ST_RESP;
        end else if ((state_q == ST_WAIT_LOW) && !acc_ready) begin
          state_d = ST_WAIT_HIGH;
        end else begin
          state_d = state_q;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          jobs_done_d = jobs_done_q + 16'd1;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        acc_start_d = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any in-flight job.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      job_id_q      <= '0;
      job_r_q       <= '0;
      job_qs_q      <= '0;
      start_cnt_q   <= '0;
      wdog_q        <= '0;
      acc_start_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_r_q       <= '0;
      rsp_qa_q      <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      jobs_done_q   <= 16'd0;
      timeouts_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      job_id_q      <= job_id_d;
      job_r_q       <= job_r_d;
      job_qs_q      <= job_qs_d;
      start_cnt_q   <= start_cnt_d;
      wdog_q        <= wdog_d;
      acc_start_q   <= acc_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_r_q       <= rsp_r_d;
      rsp_qa_q      <= rsp_qa_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      jobs_done_q   <= jobs_done_d;
      timeouts_q    <= timeouts_d;
    end
  end

endmodule

// File: tb/tb_bsw_job_scheduler.sv
// Directed bench for bsw_job_scheduler. u_dut: START_CYC=1, TIMEOUT=64 with an
// accelerator model; u_dut3: START_CYC=3, accelerator driven step by step.
module tb_bsw_job_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid, req_ready;
  logic [95:0] req_R, req_Q;
  logic        rsp_valid, rsp_ready, rsp_timeout, acc_start, acc_ready, busy;
  logic [1:0]  rsp_id;
  logic [29:0] rsp_R_aligned, rsp_Q_aligned, acc_R_aligned, acc_Q_aligned;
  logic [23:0] acc_R, acc_Q;
  logic [15:0] jobs_done;
  logic [7:0]  timeouts;

  logic [3:0]  req_valid3, req_ready3;
  logic        rsp_valid3, rsp_ready3, rsp_timeout3, acc_start3, acc_ready3, busy3;
  logic [1:0]  rsp_id3;
  logic [29:0] rsp_R_aligned3, rsp_Q_aligned3, acc_R_aligned3, acc_Q_aligned3;
  logic [23:0] acc_R3, acc_Q3;
  logic [15:0] jobs_done3;
  logic [7:0]  timeouts3;

  int n_tests, n_fail, cyc;
  int model_delay, mcnt;
  bit model_never;
  int t0, last, w;

  bsw_job_scheduler #(.NREQ(4), .RLEN(12), .ALEN(15), .START_CYC(1), .TIMEOUT(64)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_R(req_R), .req_Q(req_Q), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_R_aligned(rsp_R_aligned), .rsp_Q_aligned(rsp_Q_aligned),
    .rsp_timeout(rsp_timeout), .acc_start(acc_start), .acc_R(acc_R), .acc_Q(acc_Q),
    .acc_R_aligned(acc_R_aligned), .acc_Q_aligned(acc_Q_aligned), .acc_ready(acc_ready),
    .busy(busy), .jobs_done(jobs_done), .timeouts(timeouts)
  );

  bsw_job_scheduler #(.NREQ(4), .RLEN(12), .ALEN(15), .START_CYC(3), .TIMEOUT(1024)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_R(req_R), .req_Q(req_Q), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_id(rsp_id3), .rsp_R_aligned(rsp_R_aligned3), .rsp_Q_aligned(rsp_Q_aligned3),
    .rsp_timeout(rsp_timeout3), .acc_start(acc_start3), .acc_R(acc_R3), .acc_Q(acc_Q3),
    .acc_R_aligned(acc_R_aligned3), .acc_Q_aligned(acc_Q_aligned3), .acc_ready(acc_ready3),
    .busy(busy3), .jobs_done(jobs_done3), .timeouts(timeouts3)
  );

  initial forever #5 clk = ~clk;

  // Accelerator model for u_dut: done level drops on start, rises model_delay
  // negedges later with R/Q padded by 6'h00 / 6'h3F.
  initial begin
    acc_ready = 1'b0; acc_R_aligned = 30'd0; acc_Q_aligned = 30'd0; mcnt = 0;
    forever begin
      @(negedge clk);
      if (acc_start) begin
        acc_ready = 1'b0;
        mcnt = model_never ? 0 : model_delay;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          acc_ready = 1'b1;
          acc_R_aligned = {6'h00, acc_R};
          acc_Q_aligned = {6'h3F, acc_Q};
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    reset_n = 1'b0; req_valid = 4'hF; req_valid3 = 4'h0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    req_R = 96'd0; req_Q = 96'd0; model_delay = 50; model_never = 1'b0;
    acc_ready3 = 1'b0; acc_R_aligned3 = 30'd0; acc_Q_aligned3 = 30'd0;
    req_R[0 +: 24] = 24'h1B1B1B;  req_Q[0 +: 24] = 24'h1B1B1A;
    req_R[24 +: 24] = 24'h5A5A5A; req_Q[24 +: 24] = 24'hA5A5A5;
    req_R[48 +: 24] = 24'hC0FFEE; req_Q[48 +: 24] = 24'h123456;
    req_R[72 +: 24] = 24'h0F0F0F; req_Q[72 +: 24] = 24'hF0F0F0;
    repeat (3) step();
    // Reset state
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_acc_start", acc_start, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_jobs_done", jobs_done, 16'd0);
    chk("rst_acc_R", acc_R, 24'd0);
    req_valid = 4'h0;
    reset_n = 1'b1;
    step();

    // Single job on requester 0
    rsp_ready = 1'b1; model_delay = 50;
    req_valid = 4'b0001; #1;
    chk("t1_req_ready", req_ready, 4'b0001);
    t0 = cyc;
    step(); req_valid = 4'b0000;
    chk("t1_start_T1", acc_start, 1'b1);
    chk("t1_acc_R", acc_R, 24'h1B1B1B);
    chk("t1_acc_Q", acc_Q, 24'h1B1B1A);
    chk("t1_busy", busy, 1'b1);
    step();
    chk("t1_start_T2", acc_start, 1'b0);
    for (int i = 0; i < 100 && !acc_ready; i++) step();
    chk("t1_done_cycle", cyc - t0, 51);
    chk("t1_rsp_early", rsp_valid, 1'b0);
    step();
    chk("t1_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rsp_id", rsp_id, 2'd0);
    chk("t1_rsp_R", rsp_R_aligned, 30'h001B1B1B);
    chk("t1_rsp_Q", rsp_Q_aligned, 30'h3F1B1B1A);
    chk("t1_rsp_timeout", rsp_timeout, 1'b0);
    step();
    chk("t1_rsp_fall", rsp_valid, 1'b0);
    chk("t1_jobs_done", jobs_done, 16'd1);
    chk("t1_idle", busy, 1'b0);

    // Reset in IDLE, then all four requesters held valid
    reset_n = 1'b0; #1;
    chk("t2_rst_jobs", jobs_done, 16'd0);
    step(); reset_n = 1'b1; step();
    model_delay = 2;
    req_valid = 4'hF; #1;
    last = 0;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (req_ready == 4'h0 && w < 40) begin step(); w++; end
      chk("t2_grant", req_ready, 4'b0001 << (k % 4));
      if (k > 0) chk("t2_spacing", cyc - last, 5);
      last = cyc;
      step();
    end
    req_valid = 4'h0;
    for (int i = 0; i < 20 && busy; i++) step();
    chk("t2_idle", busy, 1'b0);
    chk("t2_jobs_done", jobs_done, 16'd6);

    // Back-pressure on the response channel
    rsp_ready = 1'b0;
    req_valid = 4'b1110; #1;
    chk("t3_grant", req_ready, 4'b0100);
    step();
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    for (int i = 0; i < 20; i++) begin
      chk("t3_hold_valid", rsp_valid, 1'b1);
      chk("t3_hold_id", rsp_id, 2'd2);
      chk("t3_hold_R", rsp_R_aligned, 30'h00C0FFEE);
      chk("t3_hold_Q", rsp_Q_aligned, 30'h3F123456);
      chk("t3_no_grant", req_ready, 4'h0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("t3_next_grant", req_ready, 4'b1000);
    chk("t3_jobs_done", jobs_done, 16'd7);
    step(); req_valid = 4'h0;
    for (int i = 0; i < 20 && busy; i++) step();
    chk("t3_idle", busy, 1'b0);

    // Watchdog: accelerator never completes
    model_never = 1'b1;
    req_valid = 4'b0001; #1;
    chk("t4_grant", req_ready, 4'b0001);
    step(); req_valid = 4'h0;
    t0 = cyc;
    for (int i = 0; i < 100 && !rsp_valid; i++) step();
    chk("t4_to_latency", cyc - t0, 64);
    chk("t4_timeout_flag", rsp_timeout, 1'b1);
    chk("t4_R_zero", rsp_R_aligned, 30'd0);
    chk("t4_Q_zero", rsp_Q_aligned, 30'd0);
    chk("t4_timeouts", timeouts, 8'd1);
    step();
    chk("t4_jobs_done", jobs_done, 16'd9);
    model_never = 1'b0; model_delay = 2;
    req_valid = 4'b0010; #1;
    chk("t4_next_grant", req_ready, 4'b0010);
    step(); req_valid = 4'h0;
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    chk("t4_next_flag", rsp_timeout, 1'b0);
    chk("t4_next_id", rsp_id, 2'd1);
    chk("t4_next_R", rsp_R_aligned, 30'h005A5A5A);
    chk("t4_next_Q", rsp_Q_aligned, 30'h3FA5A5A5);
    step();
    chk("t4_next_timeouts", timeouts, 8'd1);
    chk("t4_next_jobs", jobs_done, 16'd10);

    // u_dut3: 3-cycle start, stale done high 3 cycles, low 5, then high
    rsp_ready3 = 1'b1;
    acc_ready3 = 1'b1; acc_R_aligned3 = 30'h3FFFFFFF; acc_Q_aligned3 = 30'h2AAAAAAA;
    req_valid3 = 4'b0010; #1;
    chk("t5_grant", req_ready3, 4'b0010);
    for (int i = 1; i <= 10; i++) begin
      step();
      req_valid3 = 4'h0;
      acc_ready3 = (i <= 3) || (i >= 9);
      if (i == 9) begin
        acc_R_aligned3 = 30'h005A5A5A;
        acc_Q_aligned3 = 30'h3FA5A5A5;
      end
      chk("t5_acc_start", acc_start3, (i <= 3));
      chk("t5_rsp_valid", rsp_valid3, (i == 10));
    end
    chk("t5_acc_R", acc_R3, 24'h5A5A5A);
    chk("t5_acc_Q", acc_Q3, 24'hA5A5A5);
    chk("t5_rsp_R", rsp_R_aligned3, 30'h005A5A5A);
    chk("t5_rsp_Q", rsp_Q_aligned3, 30'h3FA5A5A5);
    chk("t5_rsp_id", rsp_id3, 2'd1);
    chk("t5_rsp_timeout", rsp_timeout3, 1'b0);
    step();
    chk("t5_jobs_done", jobs_done3, 16'd1);
    chk("t5_timeouts", timeouts3, 8'd0);
    chk("t5_idle", busy3, 1'b0);

    // Reset asserted while waiting for completion
    model_delay = 30;
    req_valid = 4'b0100; #1;
    chk("t6_grant", req_ready, 4'b0100);
    step(); req_valid = 4'h0;
    step(); step();
    chk("t6_busy_before", busy, 1'b1);
    reset_n = 1'b0; #1;
    chk("t6_busy_async", busy, 1'b0);
    chk("t6_start_async", acc_start, 1'b0);
    chk("t6_rsp_async", rsp_valid, 1'b0);
    chk("t6_acc_R_async", acc_R, 24'd0);
    chk("t6_jobs_async", jobs_done, 16'd0);
    step(); step();
    reset_n = 1'b1;
    req_valid = 4'b1001; #1;
    chk("t6_grant_from0", req_ready, 4'b0001);
    step(); req_valid = 4'h0;
    for (int i = 0; i < 60 && !rsp_valid; i++) step();
    chk("t6_rsp_valid", rsp_valid, 1'b1);
    chk("t6_rsp_id", rsp_id, 2'd0);
    chk("t6_rsp_R", rsp_R_aligned, 30'h001B1B1B);
    step();
    chk("t6_jobs_done", jobs_done, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
